// File: rtl/place_ctrl_if.sv
// Placement request/status bundle between the game front end and place_ctrl.
// The master drives requests and display read addresses; the slave returns status and the board cell.
interface place_ctrl_if;
    logic       place;
    logic [3:0] x;
    logic [3:0] y;
    logic [1:0] color;
    logic       switch;
    logic       busy;
    logic       reject;
    logic [1:0] win;
    logic       draw;
    logic [3:0] rd_x;
    logic [3:0] rd_y;
    logic [1:0] rd_cell;

    modport master (
        output place, x, y, color, rd_x, rd_y,
        input  switch, busy, reject, win, draw, rd_cell
    );

    modport slave (
        input  place, x, y, color, rd_x, rd_y,
        output switch, busy, reject, win, draw, rd_cell
    );
endinterface

// File: rtl/place_ctrl.sv
// Stone placement controller: checks, writes and (with PLACE_CTRL_WIN_DETECT_EN) scans for a win.
// Switch 3 cycles after accept without the scan; requests outside IDLE are dropped, never queued.
module place_ctrl #(
    parameter int BOARD   = 15,
    parameter int WIN_LEN = 5
) (
    input  logic        clk,
    input  logic        resetn,
    place_ctrl_if.slave bus
);
    localparam int         CELLS = BOARD * BOARD;
    localparam int         IW    = $clog2(CELLS);
    localparam logic [3:0] LAST  = 4'(BOARD - 1);
    // A 16x16 board wraps the 8-bit counter to 0 exactly on the last move, so the truncated compare holds
    localparam logic [7:0] FULL  = 8'(CELLS);

`ifdef PLACE_CTRL_WIN_DETECT_EN
    typedef enum logic [2:0] {IDLE, CHECK, SCAN, DONE, OVER} state_t;
`else
    typedef enum logic [2:0] {IDLE, CHECK, DONE, OVER} state_t;
`endif

    state_t     state, state_d;
    logic [1:0] cells [CELLS];
    logic [3:0] lx, ly;
    logic [1:0] lcol;
    logic [7:0] moves;
    logic       switch_q, reject_q, draw_q;
    logic       switch_d, reject_d, draw_d;
    logic [1:0] tgt;
    logic       legal;

    function automatic logic in_range(input logic [3:0] cx, input logic [3:0] cy);
        return (int'(cx) < BOARD) && (int'(cy) < BOARD);
    endfunction

    function automatic logic [IW-1:0] cell_idx(input logic [3:0] cx, input logic [3:0] cy);
        return IW'(int'(cy) * BOARD + int'(cx));
    endfunction

    assign tgt   = in_range(lx, ly) ? cells[cell_idx(lx, ly)] : 2'b00;
    assign legal = in_range(lx, ly) && (tgt == 2'b00);

    assign bus.rd_cell = in_range(bus.rd_x, bus.rd_y) ? cells[cell_idx(bus.rd_x, bus.rd_y)] : 2'b00;
    assign bus.switch  = switch_q;
    assign bus.reject  = reject_q;
    assign bus.draw    = draw_q;
    assign bus.busy    = (state != IDLE) && (state != OVER);

`ifdef PLACE_CTRL_WIN_DETECT_EN
    localparam logic [7:0] STEP_MAX = 8'(WIN_LEN - 1);
    localparam logic [7:0] RUN_WIN  = 8'(WIN_LEN);

    logic [1:0] dir;
    logic       side;
    logic [3:0] cx, cy, nx, ny;
    logic [7:0] steps, run;
    logic [1:0] win_q;
    logic       xn, xp, yn, yp;
    logic       blocked, hit, walk_end, got_win, last_walk;

    // Direction order: horizontal, vertical, diagonal, anti-diagonal; side 0 walks negative first
    always_comb begin
        xn = 1'b0;
        xp = 1'b0;
        yn = 1'b0;
        yp = 1'b0;
        case (dir)
            2'd0:    begin xn = ~side; xp = side; end
            2'd1:    begin yn = ~side; yp = side; end
            2'd2:    begin xn = ~side; xp = side; yn = ~side; yp = side; end
            default: begin xn = ~side; xp = side; yn = side;  yp = ~side; end
        endcase
    end

    assign blocked   = (xn && cx == 4'd0) || (xp && cx == LAST) ||
                       (yn && cy == 4'd0) || (yp && cy == LAST);
    assign nx        = xn ? cx - 4'd1 : (xp ? cx + 4'd1 : cx);
    assign ny        = yn ? cy - 4'd1 : (yp ? cy + 4'd1 : cy);
    assign hit       = !blocked && in_range(nx, ny) && (cells[cell_idx(nx, ny)] == lcol);
    assign got_win   = hit && ((run + 8'd1) >= RUN_WIN);
    assign walk_end  = !hit || (steps == STEP_MAX - 8'd1);
    assign last_walk = side && (dir == 2'd3);
    assign bus.win   = win_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dir   <= 2'd0;
            side  <= 1'b0;
            cx    <= 4'd0;
            cy    <= 4'd0;
            steps <= 8'd0;
            run   <= 8'd0;
            win_q <= 2'b00;
        end else if (state == CHECK) begin
            dir   <= 2'd0;
            side  <= 1'b0;
            cx    <= lx;
            cy    <= ly;
            steps <= 8'd0;
            run   <= 8'd1;
        end else if (state == SCAN) begin
            if (got_win)
                win_q <= lcol;
            if (walk_end) begin
                cx    <= lx;
                cy    <= ly;
                steps <= 8'd0;
                side  <= ~side;
                if (side) begin
                    dir <= dir + 2'd1;
                    run <= 8'd1;
                end else begin
                    run <= run + {7'd0, hit};
                end
            end else begin
                cx    <= nx;
                cy    <= ny;
                steps <= steps + 8'd1;
                run   <= run + 8'd1;
            end
        end
    end
`else
    assign bus.win = 2'b00;
`endif

    always_comb begin
        state_d  = state;
        switch_d = 1'b0;
        reject_d = 1'b0;
        draw_d   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.place)
                    state_d = CHECK;
            end
            CHECK: begin
                if (!legal) begin
                    reject_d = 1'b1;
                    state_d  = IDLE;
                end else begin
`ifdef PLACE_CTRL_WIN_DETECT_EN
                    state_d = SCAN;
`else
                    state_d = DONE;
`endif
                end
            end
`ifdef PLACE_CTRL_WIN_DETECT_EN
            SCAN: begin
                if (got_win)
                    state_d = OVER;
                else if (walk_end && last_walk)
                    state_d = DONE;
            end
`endif
            DONE: begin
                switch_d = 1'b1;
                if (moves == FULL) begin
                    draw_d  = 1'b1;
                    state_d = OVER;
                end else begin
                    state_d = IDLE;
                end
            end
            OVER:    state_d = OVER;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            switch_q <= 1'b0;
            reject_q <= 1'b0;
            draw_q   <= 1'b0;
        end else begin
            state    <= state_d;
            switch_q <= switch_d;
            reject_q <= reject_d;
            draw_q   <= draw_q | draw_d;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lx    <= 4'd0;
            ly    <= 4'd0;
            lcol  <= 2'b00;
            moves <= 8'd0;
            for (int i = 0; i < CELLS; i++)
                cells[IW'(i)] <= 2'b00;
        end else begin
            if (state == IDLE && bus.place) begin
                lx   <= bus.x;
                ly   <= bus.y;
                lcol <= bus.color;
            end
            if (state == CHECK && legal) begin
                cells[cell_idx(lx, ly)] <= lcol;
                moves                   <= moves + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_place_ctrl.sv
// Directed bench for place_ctrl on a 15x15 board, five in a row.
module tb_place_ctrl;
    logic clk = 1'b0;
    logic resetn;
    int   vectors     = 0;
    int   miscompares = 0;
    int   sw_cnt, rj_cnt, sw_cyc, rj_cyc, busy1;
    int   total_sw, total_rj;

    place_ctrl_if bus ();

    place_ctrl #(.BOARD(15), .WIN_LEN(5)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cell_check(input string tag, input logic [3:0] cx, input logic [3:0] cy,
                              input logic [1:0] exp);
        bus.rd_x = cx;
        bus.rd_y = cy;
        #1;
        check(tag, 32'(bus.rd_cell), 32'(exp));
    endtask

    // One-edge place request, then 40 sampled cycles; cycle n is the period after edge n-1 of the accept
    task automatic place_and_wait(input logic [3:0] px, input logic [3:0] py, input logic [1:0] pc);
        sw_cnt = 0;
        rj_cnt = 0;
        sw_cyc = 0;
        rj_cyc = 0;
        @(negedge clk);
        bus.place = 1'b1;
        bus.x     = px;
        bus.y     = py;
        bus.color = pc;
        @(posedge clk);
        #1;
        bus.place = 1'b0;
        busy1     = int'(bus.busy);
        for (int k = 1; k <= 40; k++) begin
            if (bus.switch) begin
                sw_cnt++;
                if (sw_cyc == 0) sw_cyc = k;
            end
            if (bus.reject) begin
                rj_cnt++;
                if (rj_cyc == 0) rj_cyc = k;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        bus.place = 1'b0;
        bus.x     = 4'd0;
        bus.y     = 4'd0;
        bus.color = 2'b01;
        bus.rd_x  = 4'd7;
        bus.rd_y  = 4'd7;
        resetn    = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'({bus.switch, bus.reject, bus.busy, bus.win, bus.draw}), 32'd0);
        cell_check("reset_cell", 4'd7, 4'd7, 2'b00);
        resetn = 1'b1;

        // First legal move
        place_and_wait(4'd7, 4'd7, 2'b01);
        check("first_busy", 32'(busy1), 32'd1);
        check("first_switch_count", 32'(sw_cnt), 32'd1);
`ifdef PLACE_CTRL_WIN_DETECT_EN
        check("first_switch_cycle", 32'(sw_cyc), 32'd11);
`else
        check("first_switch_cycle", 32'(sw_cyc), 32'd3);
`endif
        check("first_reject_count", 32'(rj_cnt), 32'd0);
        check("first_win", 32'(bus.win), 32'd0);
        cell_check("first_cell", 4'd7, 4'd7, 2'b01);

        // Occupied target
        place_and_wait(4'd7, 4'd7, 2'b10);
        check("occupied_reject_count", 32'(rj_cnt), 32'd1);
        check("occupied_reject_cycle", 32'(rj_cyc), 32'd2);
        check("occupied_switch_count", 32'(sw_cnt), 32'd0);
        cell_check("occupied_cell", 4'd7, 4'd7, 2'b01);

        // Off-board column
        place_and_wait(4'd15, 4'd3, 2'b10);
        check("offboard_reject_count", 32'(rj_cnt), 32'd1);
        check("offboard_switch_count", 32'(sw_cnt), 32'd0);
        cell_check("offboard_cell_edge", 4'd14, 4'd3, 2'b00);
        cell_check("offboard_cell_oor", 4'd15, 4'd3, 2'b00);

        // Request held while busy is dropped
        @(negedge clk);
        bus.place = 1'b1;
        bus.x     = 4'd2;
        bus.y     = 4'd2;
        bus.color = 2'b10;
        @(negedge clk);
        bus.x = 4'd3;
        bus.y = 4'd3;
        @(negedge clk);
        @(negedge clk);
        bus.place = 1'b0;
        repeat (40) @(negedge clk);
        cell_check("busy_first_cell", 4'd2, 4'd2, 2'b10);
        cell_check("busy_dropped_cell", 4'd3, 4'd3, 2'b00);

`ifndef PLACE_CTRL_WIN_DETECT_EN
        // Fill the rest of the board to reach a draw
        total_sw = 0;
        total_rj = 0;
        for (int yy = 0; yy < 15; yy++) begin
            for (int xx = 0; xx < 15; xx++) begin
                if ((xx == 7 && yy == 7) || (xx == 2 && yy == 2) || (xx == 14 && yy == 14))
                    continue;
                place_and_wait(4'(xx), 4'(yy), ((xx + yy) % 2 == 0) ? 2'b01 : 2'b10);
                total_sw += sw_cnt;
                total_rj += rj_cnt;
            end
        end
        check("fill_switch_total", 32'(total_sw), 32'd222);
        check("fill_reject_total", 32'(total_rj), 32'd0);
        check("fill_draw_before_last", 32'(bus.draw), 32'd0);
        place_and_wait(4'd14, 4'd14, 2'b10);
        check("last_draw", 32'(bus.draw), 32'd1);
        check("last_busy", 32'(bus.busy), 32'd0);
        cell_check("last_cell", 4'd14, 4'd14, 2'b10);
        place_and_wait(4'd0, 4'd0, 2'b01);
        check("over_reject_count", 32'(rj_cnt), 32'd0);
        check("over_switch_count", 32'(sw_cnt), 32'd0);
        check("over_draw_held", 32'(bus.draw), 32'd1);
`endif

        // Reset in the middle of a move
        @(negedge clk);
        bus.place = 1'b1;
        bus.x     = 4'd9;
        bus.y     = 4'd9;
        bus.color = 2'b10;
        @(negedge clk);
        bus.place = 1'b0;
        @(negedge clk);
        resetn = 1'b0;
        #1;
        check("midreset_outputs", 32'({bus.switch, bus.reject, bus.busy, bus.win, bus.draw}), 32'd0);
        cell_check("midreset_cell77", 4'd7, 4'd7, 2'b00);
        cell_check("midreset_cell99", 4'd9, 4'd9, 2'b00);
        @(negedge clk);
        resetn = 1'b1;
        place_and_wait(4'd7, 4'd7, 2'b01);
        check("after_reset_switch_count", 32'(sw_cnt), 32'd1);
        check("after_reset_reject_count", 32'(rj_cnt), 32'd0);
        cell_check("after_reset_cell", 4'd7, 4'd7, 2'b01);

`ifdef PLACE_CTRL_WIN_DETECT_EN
        // Horizontal five from the left edge
        do_reset();
        total_sw = 0;
        for (int i = 0; i < 4; i++) begin
            place_and_wait(4'(i), 4'd0, 2'b01);
            total_sw += sw_cnt;
        end
        check("row_setup_switches", 32'(total_sw), 32'd4);
        check("row_setup_win", 32'(bus.win), 32'd0);
        place_and_wait(4'd4, 4'd0, 2'b01);
        check("row_win", 32'(bus.win), 32'd1);
        check("row_win_switch", 32'(sw_cnt), 32'd0);
        check("row_win_busy", 32'(bus.busy), 32'd0);
        place_and_wait(4'd5, 4'd5, 2'b01);
        check("row_over_reject", 32'(rj_cnt), 32'd0);
        check("row_over_switch", 32'(sw_cnt), 32'd0);
        cell_check("row_over_cell", 4'd5, 4'd5, 2'b00);

        // Diagonal five finished in the middle, run touching the far edge
        do_reset();
        place_and_wait(4'd10, 4'd10, 2'b01);
        place_and_wait(4'd11, 4'd11, 2'b01);
        place_and_wait(4'd13, 4'd13, 2'b01);
        place_and_wait(4'd14, 4'd14, 2'b01);
        check("diag_setup_win", 32'(bus.win), 32'd0);
        place_and_wait(4'd12, 4'd12, 2'b01);
        check("diag_win", 32'(bus.win), 32'd1);
        check("diag_win_switch", 32'(sw_cnt), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
